// File: rtl/exec_muldiv_iter_if.sv
// Handshake bundle between the execute-stage decode/hazard logic and the iterative mul/div unit.
// MULDIV_SIGNED_EN adds the operand sign request line.
interface exec_muldiv_iter_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             kill;
`ifdef MULDIV_SIGNED_EN
   logic             sign;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             div_by_zero;
   logic             err;

`ifdef MULDIV_SIGNED_EN
   modport master (output start, op, a, b, kill, sign,
                   input  busy, done, result, div_by_zero, err);
   modport slave  (input  start, op, a, b, kill, sign,
                   output busy, done, result, div_by_zero, err);
`else
   modport master (output start, op, a, b, kill,
                   input  busy, done, result, div_by_zero, err);
   modport slave  (input  start, op, a, b, kill,
                   output busy, done, result, div_by_zero, err);
`endif
endinterface

// File: rtl/exec_muldiv_iter.sv
// Iterative unsigned MUL/MULH/DIV/REM unit (shift-add / restoring division) for the execute stage.
// Optional feature macro: MULDIV_SIGNED_EN enables two's-complement operands via the sign input.
module exec_muldiv_iter #(
   parameter int WIDTH          = 16,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic                clk,
   input logic                rst,
   exec_muldiv_iter_if.slave  bus
);
   localparam int ITER = WIDTH / BITS_PER_CYCLE;
   localparam int CW   = $clog2(ITER) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [CW-1:0]      count;
   logic [1:0]         opQ;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   opnd;

   logic [WIDTH-1:0]   aMag;
   logic [WIDTH-1:0]   bMag;
   logic [WIDTH-1:0]   accNext;
   logic [WIDTH-1:0]   loNext;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   resSel;

`ifdef MULDIV_SIGNED_EN
   logic aNeg;
   logic bNeg;
   logic negStart;
   logic negQ;

   // Magnitudes enter the datapath; negQ records whether the final value must be negated.
   always_comb begin
      aNeg     = bus.sign & bus.a[WIDTH-1];
      bNeg     = bus.sign & bus.b[WIDTH-1];
      aMag     = aNeg ? -bus.a : bus.a;
      bMag     = bNeg ? -bus.b : bus.b;
      negStart = (bus.op == 2'b11) ? aNeg : (aNeg ^ bNeg);
   end
`else
   always_comb begin
      aMag = bus.a;
      bMag = bus.b;
   end
`endif

   // One or two radix-2 steps per clock; acc/lo form the product or remainder/quotient pair.
   always_comb begin
      accNext = acc;
      loNext  = lo;
      shifted = '0;
      sum     = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (opQ[1]) begin
            shifted = {accNext, loNext[WIDTH-1]};
            loNext  = {loNext[WIDTH-2:0], 1'b0};
            if (shifted >= {1'b0, opnd}) begin
               accNext   = shifted[WIDTH-1:0] - opnd;
               loNext[0] = 1'b1;
            end else begin
               accNext = shifted[WIDTH-1:0];
            end
         end else begin
            sum     = {1'b0, accNext} + (loNext[0] ? {1'b0, opnd} : '0);
            loNext  = {sum[0], loNext[WIDTH-1:1]};
            accNext = sum[WIDTH:1];
         end
      end
   end

   // A zero divisor naturally yields all-ones quotient and remainder == dividend.
   always_comb begin
`ifdef MULDIV_SIGNED_EN
      prod = negQ ? -{accNext, loNext} : {accNext, loNext};
      quo  = (opnd == '0) ? '1 : (negQ ? -loNext : loNext);
      rem  = negQ ? -accNext : accNext;
`else
      prod = {accNext, loNext};
      quo  = loNext;
      rem  = accNext;
`endif
      case (opQ)
         2'b00:   resSel = prod[WIDTH-1:0];
         2'b01:   resSel = prod[2*WIDTH-1:WIDTH];
         2'b10:   resSel = quo;
         default: resSel = rem;
      endcase
   end

   // Control FSM with registered status outputs; kill overrides everything but reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         count           <= '0;
         opQ             <= 2'b00;
         acc             <= '0;
         lo              <= '0;
         opnd            <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.result      <= '0;
         bus.div_by_zero <= 1'b0;
         bus.err         <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         negQ            <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         if (bus.kill) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (bus.start) begin
                     state    <= RUN;
                     bus.busy <= 1'b1;
                     count    <= '0;
                     opQ      <= bus.op;
                     acc      <= '0;
                     opnd     <= bus.op[1] ? bMag : aMag;
                     lo       <= bus.op[1] ? aMag : bMag;
`ifdef MULDIV_SIGNED_EN
                     negQ     <= negStart;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end
               RUN: begin
                  acc   <= accNext;
                  lo    <= loNext;
                  count <= count + 1'b1;
                  if (bus.start) begin
                     bus.err <= 1'b1;
                  end
                  if (count == CW'(ITER - 1)) begin
                     state           <= DONE;
                     bus.busy        <= 1'b0;
                     bus.done        <= 1'b1;
                     bus.result      <= resSel;
                     bus.div_by_zero <= opQ[1] && (opnd == '0);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
